// File: rtl/seg_source_arbiter_if.sv
// Request/value/blink bundle from three display sources and the
// registered grant/digits result returned by the arbiter.
interface seg_source_arbiter_if;
    logic [2:0]  req;
    logic [11:0] value0;
    logic [11:0] value1;
    logic [11:0] value2;
    logic [2:0]  blink;
    logic [2:0]  grant;
    logic [11:0] digits;

    modport master (
        output req, value0, value1, value2, blink,
        input  grant, digits
    );

    modport slave (
        input  req, value0, value1, value2, blink,
        output grant, digits
    );
endinterface

// File: rtl/seg_source_arbiter.sv
// Round-robin owner of a 3-digit display with minimum hold time,
// post-release linger and optional per-source blinking.
module seg_source_arbiter #(
    parameter int unsigned HOLD_CYCLES  = 100000000,
    parameter int unsigned BLINK_CYCLES = 25000000,
    parameter logic [11:0] IDLE_VALUE   = 12'h000
) (
    input logic                 clk,
    input logic                 rst_n,
    seg_source_arbiter_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OWN, LINGER} state_t;

    state_t      state, state_d;
    logic [1:0]  owner, owner_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic [BW-1:0] blink_cnt, blink_d;
    logic        phase, phase_d;
    logic [2:0]  grant_q, grant_d;
    logic [11:0] digits_q, digits_d;
    logic        load;
    logic [11:0] sel_val;

    logic [2:0] own_mask;
    logic [2:0] others;
    logic       own_req;
    logic       own_blink;
    logic       expired;

    function automatic logic [1:0] rr_pick(input logic [2:0] mask,
                                           input logic [1:0] last);
        logic [1:0] pick;
        int idx;
        pick = last;
        // Walk farthest-first so the nearest requester after last wins.
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(last) + k) % 3;
            if (mask[idx]) pick = 2'(idx);
        end
        return pick;
    endfunction

    // owner doubles as the round-robin pointer outside OWN.
    assign own_mask  = 3'(3'b001 << owner);
    assign others    = bus.req & ~own_mask;
    assign own_req   = |(bus.req & own_mask);
    assign own_blink = |(bus.blink & own_mask);
    assign expired   = (hold_cnt == HOLD_MAX);

    always_comb begin
        state_d = state;
        owner_d = owner;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|bus.req) begin
                    load    = 1'b1;
                    owner_d = rr_pick(bus.req, owner);
                end
            end
            OWN: begin
                if (!expired) begin
                    if (!own_req) state_d = LINGER;
                end else if (|others) begin
                    load    = 1'b1;
                    owner_d = rr_pick(others, owner);
                end else if (!own_req) begin
                    state_d = IDLE;
                end
            end
            LINGER: begin
                if (expired) begin
                    if (|bus.req) begin
                        load    = 1'b1;
                        owner_d = rr_pick(bus.req, owner);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) state_d = OWN;
    end

    always_comb begin
        hold_d  = '0;
        blink_d = '0;
        phase_d = 1'b1;
        if (!load && state_d != IDLE) begin
            hold_d = expired ? hold_cnt : hold_cnt + HW'(1);
        end
        if (!load && state_d == OWN && own_blink) begin
            if (blink_cnt == BLINK_MAX) begin
                phase_d = ~phase;
            end else begin
                blink_d = blink_cnt + BW'(1);
                phase_d = phase;
            end
        end
    end

    always_comb begin
        sel_val = IDLE_VALUE;
        unique case (owner_d)
            2'd0:    sel_val = bus.value0;
            2'd1:    sel_val = bus.value1;
            2'd2:    sel_val = bus.value2;
            default: sel_val = IDLE_VALUE;
        endcase
    end

    always_comb begin
        grant_d  = 3'b000;
        digits_d = IDLE_VALUE;
        unique case (state_d)
            OWN: begin
                grant_d  = 3'(3'b001 << owner_d);
                digits_d = phase_d ? sel_val : IDLE_VALUE;
            end
            LINGER:  digits_d = digits_q;
            default: digits_d = IDLE_VALUE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 2'd2;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            grant_q   <= 3'b000;
            digits_q  <= IDLE_VALUE;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            hold_cnt  <= hold_d;
            blink_cnt <= blink_d;
            phase     <= phase_d;
            grant_q   <= grant_d;
            digits_q  <= digits_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.digits = digits_q;
endmodule

// File: doc/seg_source_arbiter.md
SEG_SOURCE_ARBITER -- requirements
Module: seg_source_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 100000000, minimum ownership time in clk cycles (>=1; ~1 s at 100MHz).
REQ-002 SHALL have parameter BLINK_CYCLES, default 25000000, blink half-period in clk cycles (>=1).
REQ-003 SHALL have parameter IDLE_VALUE, default 12'h000, digits shown when no source owns the display and during blink-off phase.
REQ-004 SHALL have port clk  input  1  system clock; sole clock of the block.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  3  req[i] high = source i requests the display.
REQ-007 SHALL have port value0 / value1 / value2  input  12 each  3-hex-digit value of source 0/1/2.
REQ-008 SHALL have port blink  input  3  blink[i] high = source i's value blinks while it owns the display.
REQ-009 SHALL have port grant  output  3  one-hot owner indication, or 3'b000 when no owner; registered.
REQ-010 SHALL have port digits  output  12  value for the 3-digit display driver; registered.

Function
REQ-011 SHALL implement states IDLE, OWN, LINGER, with an owner index (0..2) and a round-robin last-owner pointer.
REQ-012 IDLE: grant=000, digits=IDLE_VALUE; if any req bit high at edge N, SHALL enter OWN with grant and digits valid from edge N (visible cycle N+1).
REQ-013 Arbitration SHALL be round-robin: search starts at (last_owner+1) mod 3, wraps, picks first set req bit; last_owner is 2 out of reset so source 0 wins first.
REQ-014 On entering OWN, hold counter SHALL clear to 0 and increment each cycle, saturating; hold is expired once HOLD_CYCLES cycles of ownership have elapsed.
REQ-015 OWN: digits SHALL register value<owner> every cycle (1-cycle latency from value change to digits).
REQ-016 OWN, hold not expired: no preemption; other req bits ignored.
REQ-017 OWN, hold expired, another req bit high: SHALL switch directly to the round-robin winner among other requesters, clear hold counter, update last_owner.
REQ-018 OWN, hold expired, no other requester, owner req high: SHALL keep ownership indefinitely.
REQ-019 Owner drops req before expiry: SHALL enter LINGER, grant=000, digits frozen at last registered value until expiry.
REQ-020 Owner drops req at/after expiry: SHALL arbitrate same edge; winner -> OWN, none -> IDLE.
REQ-021 LINGER at expiry: any req -> OWN with round-robin winner (former owner eligible); none -> IDLE. Requests during LINGER before expiry SHALL be ignored.
REQ-022 Blink: in OWN with blink[owner] high, phase SHALL toggle every BLINK_CYCLES cycles, starting "on" at each grant change; off phase digits=IDLE_VALUE, on phase digits=value<owner>.
REQ-023 blink[owner] low: digits SHALL show value<owner> continuously; blink counter held at 0, phase "on".
REQ-024 Simultaneous owner drop and expiry with another req high SHALL produce a direct switch (no LINGER/IDLE cycle).
REQ-025 grant SHALL never have more than one bit set.
REQ-026 Counter widths SHALL hold HOLD_CYCLES and BLINK_CYCLES without overflow.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, grant=000, digits=IDLE_VALUE, hold and blink counters 0, phase "on", last_owner=2.
REQ-028 Reset asserted mid-OWN/LINGER SHALL abandon ownership immediately; first grant after release follows REQ-013.

Verification (HOLD_CYCLES=4, BLINK_CYCLES=2, IDLE_VALUE=12'h000)
REQ-029 req=001, value0=12'h123 at edge 0 -> grant=001, digits=12'h123 after edge 0; value0->12'h456 -> digits=12'h456 one cycle later.
REQ-030 Source 0 owns, req=011 from edge 1 -> grant stays 001 through hold expiry, then grant=010, digits=value1; req=111 after -> next switch goes to 100.
REQ-031 Source 0 owns, drops req after 2 cycles -> grant=000, digits frozen at 12'h123 until expiry; req=000 -> digits=12'h000 (IDLE).
REQ-032 Source 1 owns, blink[1]=1, value1=12'hABC -> digits alternates 12'hABC x2 cycles, 12'h000 x2 cycles, repeating.
REQ-033 Owner drops req on the expiry edge with req[2]=1 -> grant 001->100 directly, no 000 cycle.
REQ-034 rst_n low mid-OWN -> grant=000, digits=12'h000 asynchronously; release with req=111 -> grant=001.
